// File: rtl/clint_pkg.sv
// Shared constants and decode type for the multi-hart core-local interruptor.
package clint_pkg;

  // Register group offsets inside the 64 KiB window
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  // Compare registers come up at all-ones so no timer interrupt fires out of reset
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Result of decoding one request address
  typedef enum logic [2:0] {
    DEC_MSIP,
    DEC_CMP_LO,
    DEC_CMP_HI,
    DEC_TIME_LO,
    DEC_TIME_HI,
    DEC_ERR
  } dec_e;

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit machine timer with independent 32-bit half write ports.
// A write to either half wins over a same-cycle tick and restarts the prescaler.
module clint_mtime_counter #(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime,
  output logic        tick
);

  // Keep at least one prescaler bit so TICK_DIV==1 still elaborates cleanly
  localparam int              PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PS_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler_reg;
  logic [63:0]   mtime_reg;

  // With TICK_DIV==1 the prescaler is pinned at 0 == PS_MAX, so tick is constant 1
  assign tick  = (prescaler_reg == PS_MAX);
  assign mtime = mtime_reg;

  // Prescaler: wraps at TICK_DIV-1, restarts on any mtime write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_reg <= '0;
    end else if (wr_lo || wr_hi || tick) begin
      prescaler_reg <= '0;
    end else begin
      prescaler_reg <= prescaler_reg + PW'(1);
    end
  end

  // mtime: a half write replaces that half only; otherwise increment on tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_reg <= 64'd0;
    end else if (wr_lo) begin
      mtime_reg[31:0] <= wdata;
    end else if (wr_hi) begin
      mtime_reg[63:32] <= wdata;
    end else if (tick) begin
      mtime_reg <= mtime_reg + 64'd1;
    end
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: shared mtime, per-hart msip and mtimecmp,
// valid/ready register port with a single response register and error reporting.
module clint_mh
  import clint_pkg::*;
#(
  parameter int          NUM_HARTS = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_HARTS-1:0] msw_irq,
  output logic [NUM_HARTS-1:0] mtimer_irq
);

  localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

  logic [15:0]          off;
  logic [15:0]          idx;
  logic [HW-1:0]        hart;
  dec_e                 dec;
  logic [NUM_HARTS-1:0] hart_hit;
  logic [NUM_HARTS-1:0] cmp_hit;

  logic                 accept;
  logic                 wr;
  logic                 wr_msip;
  logic                 wr_cmp_lo;
  logic                 wr_cmp_hi;
  logic                 wr_time_lo;
  logic                 wr_time_hi;

  logic [NUM_HARTS-1:0] msip_reg;
  logic [63:0]          mtimecmp_reg [NUM_HARTS];
  logic [NUM_HARTS-1:0] mtimer_irq_reg;
  logic                 rsp_valid_reg;
  logic [31:0]          rsp_rdata_reg;
  logic                 rsp_err_reg;
  logic [31:0]          rdata_next;

  logic [63:0]          mtime;
  logic                 tick;

  assign off = req_addr[15:0];

  // Address decode: window, alignment, register group and hart range
  always_comb begin
    dec = DEC_ERR;
    idx = 16'd0;
    if ((req_addr[31:16] == BASE_ADDR[31:16]) && (off[1:0] == 2'b00)) begin
      if (off < MTIMECMP_OFF) begin
        idx = (off - MSIP_OFF) >> 2;
        if (idx < 16'(NUM_HARTS)) dec = DEC_MSIP;
      end else if (off < MTIME_OFF) begin
        idx = (off - MTIMECMP_OFF) >> 3;
        if (idx < 16'(NUM_HARTS)) dec = off[2] ? DEC_CMP_HI : DEC_CMP_LO;
      end else if (off == MTIME_OFF) begin
        dec = DEC_TIME_LO;
      end else if (off == MTIME_OFF + 16'd4) begin
        dec = DEC_TIME_HI;
      end
    end
  end

  assign hart = idx[HW-1:0];

  // Per-hart select and compare; compare works purely on flop values
  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    assign hart_hit[gi] = (idx == 16'(gi));
    assign cmp_hit[gi]  = (mtime >= mtimecmp_reg[gi]);
  end

  assign req_ready  = ~rsp_valid_reg | rsp_ready;
  assign accept     = req_valid & req_ready;
  assign wr         = accept & req_we;
  assign wr_msip    = wr & (dec == DEC_MSIP);
  assign wr_cmp_lo  = wr & (dec == DEC_CMP_LO);
  assign wr_cmp_hi  = wr & (dec == DEC_CMP_HI);
  assign wr_time_lo = wr & (dec == DEC_TIME_LO);
  assign wr_time_hi = wr & (dec == DEC_TIME_HI);

  clint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .reset (reset),
    .wr_lo (wr_time_lo),
    .wr_hi (wr_time_hi),
    .wdata (req_wdata),
    .mtime (mtime),
    .tick  (tick)
  );

  // Read mux over current register values (pre-tick, pre-write)
  always_comb begin
    rdata_next = 32'd0;
    case (dec)
      DEC_MSIP:    rdata_next = {31'd0, msip_reg[hart]};
      DEC_CMP_LO:  rdata_next = mtimecmp_reg[hart][31:0];
      DEC_CMP_HI:  rdata_next = mtimecmp_reg[hart][63:32];
      DEC_TIME_LO: rdata_next = mtime[31:0];
      DEC_TIME_HI: rdata_next = mtime[63:32];
      default:     rdata_next = 32'd0;
    endcase
  end

  // Software interrupt pending bits: only bit 0 of the write data is kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip_reg <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_msip && hart_hit[h]) msip_reg[h] <= req_wdata[0];
      end
    end
  end

  // Timer compare registers, written one 32-bit half at a time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_reg[h] <= MTIMECMP_RST;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_cmp_lo && hart_hit[h]) mtimecmp_reg[h][31:0]  <= req_wdata;
        if (wr_cmp_hi && hart_hit[h]) mtimecmp_reg[h][63:32] <= req_wdata;
      end
    end
  end

  // Registered, level-sensitive timer interrupts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mtimer_irq_reg <= '0;
    else       mtimer_irq_reg <= cmp_hit;
  end

  // Response register: load on accept, hold until consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_rdata_reg <= req_we ? 32'd0 : rdata_next;
      rsp_err_reg   <= (dec == DEC_ERR);
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_rdata  = rsp_rdata_reg;
  assign rsp_err    = rsp_err_reg;
  assign msw_irq    = msip_reg;
  assign mtimer_irq = mtimer_irq_reg;

endmodule

// File: tb/tb_clint_mh.sv
// Directed testbench for clint_mh with two harts and a divide-by-4 timer tick.
module tb_clint_mh;

  localparam logic [31:0] B = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  msw_irq;
  logic [1:0]  mtimer_irq;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  clint_mh #(
    .NUM_HARTS (2),
    .BASE_ADDR (B),
    .TICK_DIV  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .msw_irq    (msw_irq),
    .mtimer_irq (mtimer_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // One request with rsp_ready high; returns #1 after the accepting edge
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output logic ok);
    logic acc;
    acc       = 1'b0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (req_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    ok        = acc & rsp_valid;
    rdata     = rsp_rdata;
    err       = rsp_err;
    req_valid = 1'b0;
    $display("[TB] %s addr=%h wdata=%h -> rdata=%h err=%0b ok=%0b",
             we ? "wr" : "rd", addr, wdata, rdata, err, ok);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic        er, ok;
    logic [31:0] ad [3];
    logic [31:0] ex [3];
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    idle(2);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: got valid=%b rdata=%h err=%b expected 0/00000000/0", rsp_valid, rsp_rdata, rsp_err);
    end
    tests_run++;
    if (msw_irq !== 2'b00 || mtimer_irq !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_irq: got msw=%b mtimer=%b expected 00/00", msw_irq, mtimer_irq);
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    reset = 1'b0;
    ad = '{B + 32'hBFF8, B + 32'h4000, B + 32'h4004};
    ex = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, ad[i], 32'd0, rd, er, ok);
      tests_run++;
      if (!ok || rd !== ex[i] || er !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_read %h: got rdata=%h err=%b ok=%b expected rdata=%h err=0 ok=1", ad[i], rd, er, ok, ex[i]);
      end
    end
    tests_run++;
    if (mtimer_irq !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mtimer_irq: got %b expected 00", mtimer_irq);
    end
  endtask

  task automatic test_msip;
    logic [31:0] rd;
    logic        er, ok;
    txn(1'b1, B + 32'h4, 32'd1, rd, er, ok);
    tests_run++;
    if (!ok || rd !== 32'd0 || er !== 1'b0 || msw_irq !== 2'b10) begin
      tests_failed++;
      $display("FAIL msip_write: got rdata=%h err=%b ok=%b msw=%b expected 00000000/0/1/10", rd, er, ok, msw_irq);
    end
    txn(1'b0, B + 32'h4, 32'd0, rd, er, ok);
    tests_run++;
    if (!ok || rd !== 32'd1 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL msip_read1: got rdata=%h err=%b expected 00000001 err=0", rd, er);
    end
    txn(1'b1, B + 32'h0, 32'hFFFF_FFFE, rd, er, ok);
    tests_run++;
    if (!ok || msw_irq !== 2'b10) begin
      tests_failed++;
      $display("FAIL msip_bit0_only: got msw=%b expected 10", msw_irq);
    end
    txn(1'b0, B + 32'h0, 32'd0, rd, er, ok);
    tests_run++;
    if (!ok || rd !== 32'd0 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL msip_read0: got rdata=%h err=%b expected 00000000 err=0", rd, er);
    end
  endtask

  task automatic test_tick;
    logic [31:0] rd;
    logic        er, ok;
    logic [31:0] ad1 [2];
    logic [31:0] ex1 [2];
    logic [31:0] ad2 [6];
    logic [31:0] ex2 [6];
    txn(1'b1, B + 32'hBFF8, 32'hFFFF_FFFF, rd, er, ok);
    txn(1'b1, B + 32'hBFFC, 32'h0, rd, er, ok);
    ad1 = '{B + 32'hBFFC, B + 32'hBFF8};
    ex1 = '{32'h0, 32'hFFFF_FFFF};
    for (int i = 0; i < 2; i++) begin
      txn(1'b0, ad1[i], 32'd0, rd, er, ok);
      tests_run++;
      if (!ok || rd !== ex1[i] || er !== 1'b0) begin
        tests_failed++;
        $display("FAIL tick_a%0d: got rdata=%h err=%b expected %h err=0", i, rd, er, ex1[i]);
      end
    end
    idle(1);
    ad2 = '{B + 32'hBFF8, B + 32'hBFFC, B + 32'hBFF8, B + 32'hBFF8, B + 32'hBFF8, B + 32'hBFF8};
    ex2 = '{32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 6; i++) begin
      txn(1'b0, ad2[i], 32'd0, rd, er, ok);
      tests_run++;
      if (!ok || rd !== ex2[i] || er !== 1'b0) begin
        tests_failed++;
        $display("FAIL tick_b%0d: got rdata=%h err=%b expected %h err=0", i, rd, er, ex2[i]);
      end
    end
    // Mid-period write restarts the prescaler: next increment 4 cycles later
    txn(1'b1, B + 32'hBFF8, 32'd5, rd, er, ok);
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, B + 32'hBFF8, 32'd0, rd, er, ok);
      tests_run++;
      if (!ok || rd !== ((i == 4) ? 32'd6 : 32'd5)) begin
        tests_failed++;
        $display("FAIL tick_prescale_restart%0d: got rdata=%h expected %h", i, rd, (i == 4) ? 32'd6 : 32'd5);
      end
    end
  endtask

  task automatic test_cmp;
    logic [31:0] rd;
    logic        er, ok;
    txn(1'b1, B + 32'hBFF8, 32'd0, rd, er, ok);
    txn(1'b1, B + 32'hBFFC, 32'd0, rd, er, ok);
    txn(1'b1, B + 32'h4004, 32'd0, rd, er, ok);
    txn(1'b1, B + 32'h4000, 32'd10, rd, er, ok);
    tests_run++;
    if (mtimer_irq !== 2'b00) begin
      tests_failed++;
      $display("FAIL cmp_before: got mtimer=%b expected 00", mtimer_irq);
    end
    // mtime reaches 10 on the 38th edge from here
    idle(38);
    tests_run++;
    if (mtimer_irq !== 2'b00) begin
      tests_failed++;
      $display("FAIL cmp_at_equal: got mtimer=%b expected 00", mtimer_irq);
    end
    idle(1);
    tests_run++;
    if (mtimer_irq !== 2'b01) begin
      tests_failed++;
      $display("FAIL cmp_rise: got mtimer=%b expected 01", mtimer_irq);
    end
    txn(1'b1, B + 32'h4000, 32'd100, rd, er, ok);
    tests_run++;
    if (mtimer_irq !== 2'b01) begin
      tests_failed++;
      $display("FAIL cmp_hold: got mtimer=%b expected 01", mtimer_irq);
    end
    idle(1);
    tests_run++;
    if (mtimer_irq !== 2'b00) begin
      tests_failed++;
      $display("FAIL cmp_fall: got mtimer=%b expected 00", mtimer_irq);
    end
    txn(1'b0, B + 32'h4000, 32'd0, rd, er, ok);
    tests_run++;
    if (!ok || rd !== 32'd100 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL cmp_readback: got rdata=%h err=%b expected 00000064 err=0", rd, er);
    end
  endtask

  task automatic test_backpressure;
    idle(1);
    req_we = 1'b0; req_addr = B + 32'h4000; req_wdata = 32'd0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_idle: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd100) begin
      tests_failed++;
      $display("FAIL bp_first_rsp: got valid=%b rdata=%h expected 1/00000064", rsp_valid, rsp_rdata);
    end
    req_addr = B + 32'h4;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      $display("[TB] stall cycle %0d valid=%b rdata=%h req_ready=%b", i, rsp_valid, rsp_rdata, req_ready);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd100 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b req_ready=%b expected 1/00000064/0/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_release: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd1) begin
      tests_failed++;
      $display("FAIL bp_second_rsp: got valid=%b rdata=%h expected 1/00000001", rsp_valid, rsp_rdata);
    end
    idle(1);
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd;
    logic        er, ok;
    logic        we [8];
    logic [31:0] ad [8];
    we = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ad = '{B + 32'h8, B + 32'h2, B + 32'h1000, B + 32'hBFF0,
           32'h0300_0004, B + 32'h4010, B + 32'h8, B + 32'h4006};
    for (int i = 0; i < 8; i++) begin
      txn(we[i], ad[i], 32'd0, rd, er, ok);
      tests_run++;
      if (!ok || rd !== 32'd0 || er !== 1'b1) begin
        tests_failed++;
        $display("FAIL err_access %h: got rdata=%h err=%b ok=%b expected 00000000 err=1 ok=1", ad[i], rd, er, ok);
      end
    end
    tests_run++;
    if (msw_irq !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_msip_kept: got msw=%b expected 10", msw_irq);
    end
    txn(1'b0, B + 32'h4000, 32'd0, rd, er, ok);
    tests_run++;
    if (!ok || rd !== 32'd100 || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cmp0_kept: got rdata=%h err=%b expected 00000064 err=0", rd, er);
    end
    txn(1'b0, B + 32'h400C, 32'd0, rd, er, ok);
    tests_run++;
    if (!ok || rd !== 32'hFFFF_FFFF || er !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cmp1_kept: got rdata=%h err=%b expected ffffffff err=0", rd, er);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    logic        er, ok;
    logic [31:0] ad [3];
    logic [31:0] ex [3];
    int          start;
    ad = '{B + 32'hBFFC, B + 32'h4004, B + 32'h4};
    ex = '{32'h0, 32'h0, 32'h1};
    start = cyc;
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, ad[i], 32'd0, rd, er, ok);
      tests_run++;
      if (!ok || rd !== ex[i] || er !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_read%0d: got rdata=%h err=%b expected %h err=0", i, rd, er, ex[i]);
      end
    end
    tests_run++;
    if (cyc - start !== 3) begin
      tests_failed++;
      $display("FAIL b2b_cycles: got %0d cycles expected 3", cyc - start);
    end
  endtask

  task automatic test_reset_mid;
    idle(1);
    req_we = 1'b0; req_addr = B + 32'h4; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'd1) begin
      tests_failed++;
      $display("FAIL midrst_pending: got valid=%b rdata=%h expected 1/00000001", rsp_valid, rsp_rdata);
    end
    #2 reset = 1'b1;
    #1;
    $display("[TB] async reset asserted valid=%b msw=%b", rsp_valid, msw_irq);
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || msw_irq !== 2'b00) begin
      tests_failed++;
      $display("FAIL midrst_async_clear: got valid=%b rdata=%h msw=%b expected 0/00000000/00", rsp_valid, rsp_rdata, msw_irq);
    end
    idle(1);
    reset = 1'b0;
    rsp_ready = 1'b1;
    idle(1);
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_no_replay: got valid=%b expected 0", rsp_valid);
    end
  endtask

  initial begin
    test_reset;
    test_msip;
    test_tick;
    test_cmp;
    test_backpressure;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
